net_resolve_unit: RTL and testbench
===================================

Name: net_resolve_unit

Overview:
- Parametrised, pipelined resolver for multi-driven nets.
- Takes NDRV 4-state driver vectors of WIDTH bits, resolves them under a selectable net kind: wire, wand, wor, trireg, supply0 or supply1.
- Emits the resolved vector through a valid/ready register stage.
- Trireg mode keeps per-bit charge that decays to X after a programmable number of undriven transactions.
- Sits in the simulation-support fabric as the hardware model for multi-driven net resolution.

Parameters:
- WIDTH, 6, bits per net.
- NDRV, 4, number of drivers (>=1).
- DECAY_TXN, 8, undriven accepted transactions before trireg charge becomes X; 0 means the charge never decays.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  driver set valid.
- in_ready  output  1  unit can accept.
- mode  input  3  net_mode_e, sampled with in_valid.
- drv_val  input  NDRV*WIDTH*2  per-driver, per-bit logic4_t; driver d bit b is at [(d*WIDTH+b)*2 +: 2].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts.
- res_val  output  WIDTH*2  resolved logic4_t per bit.
- res_conflict  output  WIDTH  bit had two or more non-Z drivers that disagree.
- res_decayed  output  WIDTH  bit is X solely because trireg charge decayed.

Behaviour:
Reset and handshake:
- Encoding: 00=0, 01=1, 10=Z, 11=X.
- Reset (async assert, sync deassert by the environment): out_valid=0, res_val all Z (10), res_conflict=0, res_decayed=0, charge store all X, decay counters 0, last_mode=WIRE.
- in_ready = !out_valid || out_ready (combinational, no bubble).
- Accept when in_valid && in_ready. The result is registered, giving a latency of 1 cycle.
- out_valid stays high and res_* stay stable while out_ready=0.
- Accept and drain in the same cycle is allowed; the new result replaces the old one.

Per-bit resolution (over non-Z drivers):
- WIRE: no non-Z drivers gives Z. Otherwise, any X gives X. All equal gives that value. A mix of 0 and 1 gives X with conflict=1.
- WAND: any 0 gives 0. Else any X gives X. Else any 1 gives 1. Else Z. conflict is always 0.
- WOR: any 1 gives 1. Else any X gives X. Else any 0 gives 0. Else Z. conflict is always 0.
- TRIREG: resolves as WIRE.
  - If the result is non-Z: charge takes that value and the counter clears to 0.
  - If the result is Z: output is the current charge and the counter increments, saturating at DECAY_TXN.
  - If the counter reaches DECAY_TXN (DECAY_TXN>0) on this transaction: charge and output become X and res_decayed=1 for that bit.
  - A later drive restores the bit.
- SUPPLY0 / SUPPLY1: output all 0 / all 1; drivers ignored; conflict=0.
  - Charge store and counters are untouched.

Charge state and mode changes:
- Charge and counters update only on accepted transactions, never on idle cycles.
- Accepting a mode different from last_mode, where either the old or new mode is TRIREG, resets the charge store to X and the counters to 0 before resolution.
- Unknown mode encodings (6, 7) resolve as WIRE and set every res_conflict bit to 1.
- NDRV=1: resolution reduces to pass-through, except in trireg and supply modes.
- Counter width: $clog2(DECAY_TXN+1), minimum 1.

Decomposition:
- Package net_pkg holds:
  - logic4_t (2-bit enum L0, L1, LZ, LX).
  - net_mode_e (WIRE=0, WAND=1, WOR=2, TRIREG=3, SUPPLY0=4, SUPPLY1=5).
  - Function resolve4 for pairwise wire combination.
- Sub-module net_resolve_bit: purely combinational per-bit resolver.
  - Inputs: NDRV logic4_t drivers, mode, charge, counter.
  - Outputs: next value, next charge, next counter, conflict flag, decayed flag.
  - Instantiated WIDTH times by generate.
- Top level holds the handshake register, the charge and counter arrays, and last_mode.

Test Plan:
1. Reset mid-stream: drive rst_n low while out_valid=1 -> out_valid=0 immediately, res_val=12'hAAA (all Z), charge all X.
2. WIRE contention: WIDTH=6, NDRV=4, d0=all 1, d1=all 0, d2 and d3 all Z -> res_val all X (12'hFFF), res_conflict=6'h3F, 1 cycle after accept.
3. WAND: d0 bit0=0, others all 1 -> bit0=0, bits 5..1=1, res_conflict=0.
4. TRIREG decay, DECAY_TXN=3:
   - Drive all 1, then send 3 all-Z transactions.
   - Transactions 1-2 -> output all 1, res_decayed=0.
   - Transaction 3 -> all X, res_decayed=6'h3F.
   - Next drive of all 0 -> all 0, res_decayed=0.
5. Backpressure: out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, res_val held. Then out_ready=1 -> accept and drain in the same cycle, with no lost or duplicated result.
6. Mode switch: charge all 1 in TRIREG, one SUPPLY0 transaction (output 0), back to TRIREG with all drivers Z -> output all X (charge reset by the mode change).

Source files
------------

// File: rtl/net_pkg.sv
// Shared types and helpers for the multi-driven net resolver.
// 4-state values are encoded 00=0, 01=1, 10=Z, 11=X.
package net_pkg;

  typedef enum logic [1:0] {
    L0 = 2'b00,
    L1 = 2'b01,
    LZ = 2'b10,
    LX = 2'b11
  } logic4_t;

  typedef enum logic [2:0] {
    WIRE    = 3'd0,
    WAND    = 3'd1,
    WOR     = 3'd2,
    TRIREG  = 3'd3,
    SUPPLY0 = 3'd4,
    SUPPLY1 = 3'd5
  } net_mode_e;

  // Pairwise wire combination: Z yields to the other side, disagreement is X.
  function automatic logic4_t resolve4(logic4_t a, logic4_t b);
    if (a == LZ) return b;
    if (b == LZ) return a;
    if (a == b)  return a;
    return LX;
  endfunction

  function automatic int unsigned cnt_width(int unsigned decay_txn);
    return (decay_txn == 0) ? 1 : $clog2(decay_txn + 1);
  endfunction

endpackage

// File: rtl/net_resolve_unit_if.sv
// Driver-set input stream and resolved-result output stream of the net resolver.
interface net_resolve_unit_if #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned NDRV  = 4
);

  logic                     in_valid;
  logic                     in_ready;
  logic [2:0]               mode;
  logic [NDRV*WIDTH*2-1:0]  drv_val;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH*2-1:0]       res_val;
  logic [WIDTH-1:0]         res_conflict;
  logic [WIDTH-1:0]         res_decayed;

  modport master (
    output in_valid, mode, drv_val, out_ready,
    input  in_ready, out_valid, res_val, res_conflict, res_decayed
  );

  modport slave (
    input  in_valid, mode, drv_val, out_ready,
    output in_ready, out_valid, res_val, res_conflict, res_decayed
  );

endinterface

// File: rtl/net_resolve_bit.sv
// Combinational resolver for one bit of a net: folds all drivers under the
// selected net kind and computes the next trireg charge and decay counter.
module net_resolve_bit
  import net_pkg::*;
#(
  parameter int unsigned NDRV      = 4,
  parameter int unsigned DECAY_TXN = 8,
  parameter int unsigned CNT_W     = cnt_width(DECAY_TXN)
) (
  input  logic [NDRV-1:0][1:0] drv_i,
  input  logic [2:0]           mode_i,
  input  logic [1:0]           charge_i,
  input  logic [CNT_W-1:0]     cnt_i,
  output logic [1:0]           val_o,
  output logic [1:0]           charge_o,
  output logic [CNT_W-1:0]     cnt_o,
  output logic                 conflict_o,
  output logic                 decayed_o
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DECAY_TXN);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic       has0, has1, hasx;
  logic4_t    wire_v;
  logic [1:0] wand_v, wor_v;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    has0   = 1'b0;
    has1   = 1'b0;
    hasx   = 1'b0;
    wire_v = LZ;
    for (int unsigned d = 0; d < NDRV; d++) begin
      has0   |= (logic4_t'(drv_i[d]) == L0);
      has1   |= (logic4_t'(drv_i[d]) == L1);
      hasx   |= (logic4_t'(drv_i[d]) == LX);
      wire_v  = resolve4(wire_v, logic4_t'(drv_i[d]));
    end
  end

  assign wand_v  = has0 ? L0 : hasx ? LX : has1 ? L1 : LZ;
  assign wor_v   = has1 ? L1 : hasx ? LX : has0 ? L0 : LZ;
  assign cnt_inc = (cnt_i == CntMax) ? cnt_i : cnt_i + CntOne;

  always_comb begin
    val_o      = wire_v;
    charge_o   = charge_i;
    cnt_o      = cnt_i;
    conflict_o = has0 && has1;
    decayed_o  = 1'b0;
    case (mode_i)
      WAND: begin
        val_o      = wand_v;
        conflict_o = 1'b0;
      end
      WOR: begin
        val_o      = wor_v;
        conflict_o = 1'b0;
      end
      TRIREG: begin
        if (wire_v != LZ) begin
          charge_o = wire_v;
          cnt_o    = '0;
        end else begin
          // Undriven: present the stored charge until the counter runs out.
          cnt_o = cnt_inc;
          val_o = charge_i;
          if ((DECAY_TXN != 0) && (cnt_inc == CntMax)) begin
            charge_o  = LX;
            val_o     = LX;
            decayed_o = 1'b1;
          end
        end
      end
      SUPPLY0: begin
        val_o      = L0;
        conflict_o = 1'b0;
      end
      SUPPLY1: begin
        val_o      = L1;
        conflict_o = 1'b0;
      end
      WIRE: ;
      default: conflict_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/net_resolve_unit.sv
// Pipelined multi-driven net resolver: one registered result per accepted
// driver set, with per-bit trireg charge and decay counters.
module net_resolve_unit
  import net_pkg::*;
#(
  parameter int unsigned WIDTH     = 6,
  parameter int unsigned NDRV      = 4,
  parameter int unsigned DECAY_TXN = 8,
  parameter int unsigned CNT_W     = cnt_width(DECAY_TXN)
) (
  input  logic              clk,
  input  logic              rst_n,
  net_resolve_unit_if.slave bus
);

  localparam logic [2:0]             ModeWire   = WIRE;
  localparam logic [2:0]             ModeTrireg = TRIREG;
  localparam logic [WIDTH-1:0][1:0]  AllZ       = {WIDTH{2'b10}};
  localparam logic [WIDTH-1:0][1:0]  AllX       = {WIDTH{2'b11}};

  logic                        accept, mode_switch;
  logic                        out_valid_q, out_valid_d;
  logic [WIDTH-1:0][1:0]       res_val_q, res_val_d;
  logic [WIDTH-1:0]            res_conflict_q, res_conflict_d;
  logic [WIDTH-1:0]            res_decayed_q, res_decayed_d;
  logic [WIDTH-1:0][1:0]       charge_q, charge_d, charge_eff, charge_nx, val_nx;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d, cnt_eff, cnt_nx;
  logic [WIDTH-1:0]            conflict_nx, decayed_nx;
  logic [2:0]                  last_mode_q, last_mode_d;

  assign bus.in_ready     = !out_valid_q || bus.out_ready;
  assign accept           = bus.in_valid && bus.in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.res_val      = res_val_q;
  assign bus.res_conflict = res_conflict_q;
  assign bus.res_decayed  = res_decayed_q;

  // Entering or leaving trireg discards any stored charge before resolving.
  assign mode_switch = (bus.mode != last_mode_q) &&
                       ((bus.mode == ModeTrireg) || (last_mode_q == ModeTrireg));
  assign charge_eff  = mode_switch ? AllX : charge_q;
  assign cnt_eff     = mode_switch ? '0 : cnt_q;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [NDRV-1:0][1:0] drv_b;
    for (genvar d = 0; d < NDRV; d++) begin : g_drv
      assign drv_b[d] = bus.drv_val[(d*WIDTH+b)*2 +: 2];
    end

    net_resolve_bit #(
      .NDRV      (NDRV),
      .DECAY_TXN (DECAY_TXN),
      .CNT_W     (CNT_W)
    ) u_bit (
      .drv_i      (drv_b),
      .mode_i     (bus.mode),
      .charge_i   (charge_eff[b]),
      .cnt_i      (cnt_eff[b]),
      .val_o      (val_nx[b]),
      .charge_o   (charge_nx[b]),
      .cnt_o      (cnt_nx[b]),
      .conflict_o (conflict_nx[b]),
      .decayed_o  (decayed_nx[b])
    );
  end

  always_comb begin
    out_valid_d    = out_valid_q;
    res_val_d      = res_val_q;
    res_conflict_d = res_conflict_q;
    res_decayed_d  = res_decayed_q;
    charge_d       = charge_q;
    cnt_d          = cnt_q;
    last_mode_d    = last_mode_q;
    if (accept) begin
      out_valid_d    = 1'b1;
      res_val_d      = val_nx;
      res_conflict_d = conflict_nx;
      res_decayed_d  = decayed_nx;
      charge_d       = charge_nx;
      cnt_d          = cnt_nx;
      last_mode_d    = bus.mode;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      res_val_q      <= AllZ;
      res_conflict_q <= '0;
      res_decayed_q  <= '0;
      charge_q       <= AllX;
      cnt_q          <= '0;
      last_mode_q    <= ModeWire;
    end else begin
      out_valid_q    <= out_valid_d;
      res_val_q      <= res_val_d;
      res_conflict_q <= res_conflict_d;
      res_decayed_q  <= res_decayed_d;
      charge_q       <= charge_d;
      cnt_q          <= cnt_d;
      last_mode_q    <= last_mode_d;
    end
  end

endmodule

// File: tb/tb_net_resolve_unit.sv
// Bench for net_resolve_unit: directed vector table, hand sequences for
// backpressure and reset, then random traffic against a counting model.
module tb_net_resolve_unit;
  import net_pkg::*;

  localparam int unsigned W  = 6;
  localparam int unsigned N  = 4;
  localparam int unsigned DT = 3;

  localparam logic [11:0] A0 = 12'h000;
  localparam logic [11:0] A1 = 12'h555;
  localparam logic [11:0] AZ = 12'hAAA;
  localparam logic [11:0] AX = 12'hFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  net_resolve_unit_if #(.WIDTH(W), .NDRV(N)) bus ();

  net_resolve_unit #(
    .WIDTH     (W),
    .NDRV      (N),
    .DECAY_TXN (DT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: charge codes per bit, undriven counts, last mode.
  int          m_charge[W];
  int          m_cnt[W];
  int          m_last;
  bit          exp_valid;
  logic [11:0] exp_val;
  logic [5:0]  exp_conf, exp_dec;

  typedef struct {
    logic [2:0]  mode;
    logic [47:0] drv;
    logic [11:0] val;
    logic [5:0]  conf;
    logic [5:0]  dec;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < W; b++) begin
      m_charge[b] = 3;
      m_cnt[b]    = 0;
    end
    m_last    = 0;
    exp_valid = 0;
    exp_val   = AZ;
    exp_conf  = '0;
    exp_dec   = '0;
  endtask

  task automatic model_accept(input logic [2:0] mode, input logic [47:0] drv);
    int n0, n1, nx, w, o;
    bit c, dcy;
    logic [1:0] code;
    if (int'(mode) != m_last && (mode == 3 || m_last == 3)) begin
      for (int b = 0; b < W; b++) begin
        m_charge[b] = 3;
        m_cnt[b]    = 0;
      end
    end
    m_last = int'(mode);
    for (int b = 0; b < W; b++) begin
      n0 = 0; n1 = 0; nx = 0;
      for (int d = 0; d < N; d++) begin
        code = drv[(d*W+b)*2 +: 2];
        if (code == 2'd0) n0++;
        if (code == 2'd1) n1++;
        if (code == 2'd3) nx++;
      end
      if (n0 + n1 + nx == 0)               w = 2;
      else if (nx > 0 || (n0 > 0 && n1 > 0)) w = 3;
      else                                  w = (n0 > 0) ? 0 : 1;
      o   = w;
      c   = (n0 > 0 && n1 > 0);
      dcy = 0;
      case (mode)
        3'd1: begin o = (n0 > 0) ? 0 : (nx > 0) ? 3 : (n1 > 0) ? 1 : 2; c = 0; end
        3'd2: begin o = (n1 > 0) ? 1 : (nx > 0) ? 3 : (n0 > 0) ? 0 : 2; c = 0; end
        3'd3: begin
          if (w != 2) begin
            m_charge[b] = w;
            m_cnt[b]    = 0;
          end else begin
            if (m_cnt[b] < DT) m_cnt[b]++;
            if (DT > 0 && m_cnt[b] == DT) begin
              m_charge[b] = 3;
              dcy         = 1;
            end
            o = m_charge[b];
          end
        end
        3'd4: begin o = 0; c = 0; end
        3'd5: begin o = 1; c = 0; end
        3'd0: ;
        default: c = 1;
      endcase
      exp_val[b*2 +: 2] = 2'(o);
      exp_conf[b]       = c;
      exp_dec[b]        = dcy;
    end
  endtask

  task automatic drive(input bit v, input logic [2:0] m, input logic [47:0] drv, input bit rdy);
    bus.in_valid  = v;
    bus.mode      = m;
    bus.drv_val   = drv;
    bus.out_ready = rdy;
  endtask

  // One clock: advance the model from the bench's own inputs, then settle.
  task automatic tick();
    bit acc;
    @(posedge clk);
    acc = bus.in_valid && (!exp_valid || bus.out_ready);
    if (acc) begin
      model_accept(bus.mode, bus.drv_val);
      exp_valid = 1;
    end else if (bus.out_ready) begin
      exp_valid = 0;
    end
    #1;
  endtask

  function automatic logic [47:0] rnd_drv();
    logic [47:0] v;
    int r;
    if ($urandom_range(0, 2) == 0) return {4{AZ}};
    for (int i = 0; i < N * W; i++) begin
      r = $urandom_range(0, 15);
      v[i*2 +: 2] = (r < 8) ? 2'b10 : (r < 12) ? 2'b00 : (r < 15) ? 2'b01 : 2'b11;
    end
    return v;
  endfunction

  initial begin
    tbl[0]  = '{3'd0, {AZ, AZ, A0, A1},       AX,      6'h3F, 6'h00};
    tbl[1]  = '{3'd1, {A1, A1, A1, 12'h554},  12'h554, 6'h00, 6'h00};
    tbl[2]  = '{3'd2, {AZ, AZ, 12'h400, A0},  12'h400, 6'h00, 6'h00};
    tbl[3]  = '{3'd0, {AZ, AZ, AZ, AZ},       AZ,      6'h00, 6'h00};
    tbl[4]  = '{3'd3, {AZ, AZ, AZ, A1},       A1,      6'h00, 6'h00};
    tbl[5]  = '{3'd3, {AZ, AZ, AZ, AZ},       A1,      6'h00, 6'h00};
    tbl[6]  = '{3'd3, {AZ, AZ, AZ, AZ},       A1,      6'h00, 6'h00};
    tbl[7]  = '{3'd3, {AZ, AZ, AZ, AZ},       AX,      6'h00, 6'h3F};
    tbl[8]  = '{3'd3, {AZ, AZ, AZ, A0},       A0,      6'h00, 6'h00};
    tbl[9]  = '{3'd3, {AZ, AZ, AZ, A1},       A1,      6'h00, 6'h00};
    tbl[10] = '{3'd4, {A1, A1, A1, A1},       A0,      6'h00, 6'h00};
    tbl[11] = '{3'd3, {AZ, AZ, AZ, AZ},       AX,      6'h00, 6'h00};
    tbl[12] = '{3'd6, {AZ, AZ, AZ, A1},       A1,      6'h3F, 6'h00};
    tbl[13] = '{3'd5, {AZ, AZ, AZ, A0},       A1,      6'h00, 6'h00};
    tbl[14] = '{3'd0, {AZ, AZ, A1, AX},       AX,      6'h00, 6'h00};

    model_reset();
    drive(0, 3'd0, {4{AZ}}, 1);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset res_val", 32'(bus.res_val), 32'(AZ));
    chk("reset conflict", 32'(bus.res_conflict), 0);
    chk("reset decayed", 32'(bus.res_decayed), 0);
    chk("reset in_ready", 32'(bus.in_ready), 1);

    for (int i = 0; i < 15; i++) begin
      drive(1, tbl[i].mode, tbl[i].drv, 1);
      tick();
      chk($sformatf("tbl%0d valid", i), 32'(bus.out_valid), 1);
      chk($sformatf("tbl%0d val", i), 32'(bus.res_val), 32'(tbl[i].val));
      chk($sformatf("tbl%0d conflict", i), 32'(bus.res_conflict), 32'(tbl[i].conf));
      chk($sformatf("tbl%0d decayed", i), 32'(bus.res_decayed), 32'(tbl[i].dec));
    end
    drive(0, 3'd0, {4{AZ}}, 1);
    tick();
    chk("drain valid", 32'(bus.out_valid), 0);

    // Backpressure: hold a result while the next driver set waits.
    drive(1, 3'd0, {AZ, AZ, AZ, A1}, 0);
    tick();
    chk("bp first val", 32'(bus.res_val), 32'(A1));
    drive(1, 3'd0, {AZ, AZ, AZ, A0}, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("bp%0d in_ready", i), 32'(bus.in_ready), 0);
      chk($sformatf("bp%0d valid", i), 32'(bus.out_valid), 1);
      chk($sformatf("bp%0d val", i), 32'(bus.res_val), 32'(A1));
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(bus.in_ready), 1);
    tick();
    chk("bp swap valid", 32'(bus.out_valid), 1);
    chk("bp swap val", 32'(bus.res_val), 32'(A0));
    drive(0, 3'd0, {4{AZ}}, 1);
    tick();
    chk("bp empty valid", 32'(bus.out_valid), 0);

    // Reset while a result is pending.
    drive(1, 3'd0, {AZ, AZ, AZ, A1}, 0);
    tick();
    chk("mid valid before", 32'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst valid", 32'(bus.out_valid), 0);
    chk("mid rst val", 32'(bus.res_val), 32'(AZ));
    model_reset();
    drive(0, 3'd0, {4{AZ}}, 1);
    @(negedge clk) rst_n = 1'b1;
    drive(1, 3'd3, {4{AZ}}, 1);
    tick();
    chk("mid rst charge", 32'(bus.res_val), 32'(AX));
    chk("mid rst decayed", 32'(bus.res_decayed), 0);

    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) == 0) ? 3'd3 : 3'($urandom_range(0, 7)),
            rnd_drv(), ($urandom_range(0, 3) != 0));
      tick();
      chk("rnd valid", 32'(bus.out_valid), 32'(exp_valid));
      chk("rnd in_ready", 32'(bus.in_ready), 32'(!exp_valid || bus.out_ready));
      if (exp_valid) begin
        chk("rnd val", 32'(bus.res_val), 32'(exp_val));
        chk("rnd conflict", 32'(bus.res_conflict), 32'(exp_conf));
        chk("rnd decayed", 32'(bus.res_decayed), 32'(exp_dec));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
